// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide sequencer:
// op encodings, FSM states and the default operand width.
package muldiv_pkg;

  localparam int XLEN_DEF = 32;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_e;

endpackage

// File: rtl/muldiv_core.sv
// One radix-2 iteration: shift-add for multiply, restoring compare-subtract
// for divide. {hi,lo} is the working accumulator, opnd the multiplicand/divisor.
module muldiv_core
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] opnd,
  output logic [XLEN-1:0] hi_nxt,
  output logic [XLEN-1:0] lo_nxt
);

  logic [XLEN:0] sum_s;
  logic [XLEN:0] shl_s;
  logic [XLEN:0] diff_s;

  // Single-iteration datapath step for both engines.
  always_comb begin
    sum_s  = {1'b0, hi} + {1'b0, opnd};
    shl_s  = {hi, lo[XLEN-1]};
    diff_s = shl_s - {1'b0, opnd};
    hi_nxt = hi;
    lo_nxt = lo;
    if (is_div) begin
      // Partial remainder stays below the divisor, so a clear sign bit means it fits.
      if (!diff_s[XLEN]) begin
        hi_nxt = diff_s[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b1};
      end else begin
        hi_nxt = shl_s[XLEN-1:0];
        lo_nxt = {lo[XLEN-2:0], 1'b0};
      end
    end else begin
      if (lo[0]) begin
        {hi_nxt, lo_nxt} = {sum_s, lo[XLEN-1:1]};
      end else begin
        {hi_nxt, lo_nxt} = {1'b0, hi, lo[XLEN-1:1]};
      end
    end
  end

endmodule

// File: rtl/muldiv_seq.sv
// HI/LO producer: iterative MULT/MULTU/DIV/DIVU sequencer with stall and cancel.
// Optional MULDIV_FAST_ZERO_EN: a zero B operand bypasses the iteration phase.
module muldiv_seq
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int ITER = XLEN
) (
  input  logic            clk,
  input  logic            CLR_n,
  input  logic            Start,
  input  logic [1:0]      Op,
  input  logic [XLEN-1:0] A,
  input  logic [XLEN-1:0] B,
  input  logic            Cancel,
  input  logic            HILORead,
  output logic            Busy,
  output logic            Stall,
  output logic            HIWrite,
  output logic            LOWrite,
  output logic [XLEN-1:0] HI_out,
  output logic [XLEN-1:0] LO_out,
  output logic            DivZero
);

  localparam int CW = (ITER > 1) ? $clog2(ITER) : 1;
  localparam int PW = 2 * XLEN;

  state_e          state_r, state_s;
  logic [CW-1:0]   count_r;
  logic [XLEN-1:0] hi_r, lo_r, opnd_r;
  logic            is_div_r, neg_lo_r, neg_hi_r, div_zero_r;

  logic            busy_r, hiwrite_r, lowrite_r, divzero_r;
  logic [XLEN-1:0] hi_out_r, lo_out_r;

  logic            accept_s, load_s, fast_zero_s;
  logic            is_div_s, signed_s, a_neg_s, b_neg_s, b_zero_s;
  logic [XLEN-1:0] a_mag_s, b_mag_s;
  logic [XLEN-1:0] core_hi_s, core_lo_s;
  logic [XLEN-1:0] res_hi_s, res_lo_s;
  logic [PW-1:0]   prod_s, prod_neg_s;

  assign accept_s = Start & ~Cancel;
  assign is_div_s = Op[1];
  assign signed_s = (Op == OP_MULT) || (Op == OP_DIV);
  assign a_neg_s  = signed_s & A[XLEN-1];
  assign b_neg_s  = signed_s & B[XLEN-1];
  assign a_mag_s  = a_neg_s ? (~A + XLEN'(1)) : A;
  assign b_mag_s  = b_neg_s ? (~B + XLEN'(1)) : B;
  assign b_zero_s = (B == '0);

`ifdef MULDIV_FAST_ZERO_EN
  assign fast_zero_s = b_zero_s;
`else
  assign fast_zero_s = 1'b0;
`endif

  // Next-state logic; Cancel outranks Start, and a DONE cycle may chain a new request.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          state_s = fast_zero_s ? S_DONE : S_RUN;
          load_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_RUN: begin
        if (Cancel) begin
          state_s = S_IDLE;
        end else if (count_r == '0) begin
          state_s = S_DONE;
        end else begin
          state_s = S_RUN;
        end
      end
      S_DONE: begin
        if (accept_s) begin
          state_s = fast_zero_s ? S_DONE : S_RUN;
          load_s  = 1'b1;
        end else begin
          state_s = S_IDLE;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  muldiv_core #(.XLEN(XLEN)) u_core (
    .is_div (is_div_r),
    .hi     (hi_r),
    .lo     (lo_r),
    .opnd   (opnd_r),
    .hi_nxt (core_hi_s),
    .lo_nxt (core_lo_s)
  );

  // Operand load, iteration update and iteration counter.
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      hi_r       <= '0;
      lo_r       <= '0;
      opnd_r     <= '0;
      count_r    <= '0;
      is_div_r   <= 1'b0;
      neg_lo_r   <= 1'b0;
      neg_hi_r   <= 1'b0;
      div_zero_r <= 1'b0;
    end else if (load_s) begin
      // A bypassed divide-by-zero preloads |A| so sign correction returns A in HI.
      hi_r       <= (fast_zero_s & is_div_s) ? a_mag_s : '0;
      lo_r       <= is_div_s ? a_mag_s : b_mag_s;
      opnd_r     <= is_div_s ? b_mag_s : a_mag_s;
      count_r    <= CW'(ITER - 1);
      is_div_r   <= is_div_s;
      neg_lo_r   <= a_neg_s ^ b_neg_s;
      neg_hi_r   <= a_neg_s;
      div_zero_r <= is_div_s & b_zero_s;
    end else if (state_r == S_RUN) begin
      hi_r    <= core_hi_s;
      lo_r    <= core_lo_s;
      count_r <= count_r - CW'(1);
    end else begin
      hi_r    <= hi_r;
      lo_r    <= lo_r;
      count_r <= count_r;
    end
  end

  assign prod_s     = {hi_r, lo_r};
  assign prod_neg_s = ~prod_s + PW'(1);

  // Sign correction of the magnitude results.
  always_comb begin
    res_hi_s = hi_r;
    res_lo_s = lo_r;
    if (is_div_r) begin
      res_hi_s = neg_hi_r ? (~hi_r + XLEN'(1)) : hi_r;
      if (div_zero_r) begin
        res_lo_s = {XLEN{1'b1}};
      end else begin
        res_lo_s = neg_lo_r ? (~lo_r + XLEN'(1)) : lo_r;
      end
    end else begin
      {res_hi_s, res_lo_s} = neg_lo_r ? prod_neg_s : prod_s;
    end
  end

  // Registered outputs: strobes and results follow the DONE cycle.
  always_ff @(posedge clk or negedge CLR_n) begin
    if (!CLR_n) begin
      busy_r    <= 1'b0;
      hiwrite_r <= 1'b0;
      lowrite_r <= 1'b0;
      hi_out_r  <= '0;
      lo_out_r  <= '0;
      divzero_r <= 1'b0;
    end else begin
      busy_r    <= (state_s == S_RUN);
      hiwrite_r <= (state_r == S_DONE);
      lowrite_r <= (state_r == S_DONE);
      if (state_r == S_DONE) begin
        hi_out_r  <= res_hi_s;
        lo_out_r  <= res_lo_s;
        divzero_r <= div_zero_r;
      end else begin
        hi_out_r  <= hi_out_r;
        lo_out_r  <= lo_out_r;
        divzero_r <= divzero_r;
      end
    end
  end

  assign Busy    = busy_r;
  assign Stall   = busy_r & (Start | HILORead);
  assign HIWrite = hiwrite_r;
  assign LOWrite = lowrite_r;
  assign HI_out  = hi_out_r;
  assign LO_out  = lo_out_r;
  assign DivZero = divzero_r;

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        CLR_n;
  logic        Start;
  logic [1:0]  Op;
  logic [31:0] A, B;
  logic        Cancel, HILORead;
  logic        Busy, Stall, HIWrite, LOWrite, DivZero;
  logic [31:0] HI_out, LO_out;

  int pass_cnt = 0;
  int total_cnt = 0;

`ifdef MULDIV_FAST_ZERO_EN
  localparam int ZLAT = 1;
`else
  localparam int ZLAT = 33;
`endif

  muldiv_seq #(.XLEN(32), .ITER(32)) dut (
    .clk(clk), .CLR_n(CLR_n), .Start(Start), .Op(Op), .A(A), .B(B),
    .Cancel(Cancel), .HILORead(HILORead), .Busy(Busy), .Stall(Stall),
    .HIWrite(HIWrite), .LOWrite(LOWrite), .HI_out(HI_out), .LO_out(LO_out),
    .DivZero(DivZero)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    Start = 1'b1; Op = op; A = a; B = b;
    tick();
    Start = 1'b0;
  endtask

  task automatic wait_strobe(output int n);
    n = 0;
    do begin
      tick();
      n++;
    end while (!HIWrite && n < 40);
  endtask

  task automatic test_reset();
    CLR_n = 1'b0; Start = 1'b0; Op = 2'b00; A = 32'd0; B = 32'd0;
    Cancel = 1'b0; HILORead = 1'b1;
    #3;
    total_cnt++; if (Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", Busy); else pass_cnt++;
    total_cnt++; if (Stall !== 1'b0) $display("FAIL reset_stall got %b want 0", Stall); else pass_cnt++;
    total_cnt++; if ({HIWrite, LOWrite} !== 2'b00) $display("FAIL reset_strobe got %b want 00", {HIWrite, LOWrite}); else pass_cnt++;
    total_cnt++; if ({HI_out, LO_out} !== 64'd0) $display("FAIL reset_data got %h want 0", {HI_out, LO_out}); else pass_cnt++;
    total_cnt++; if (DivZero !== 1'b0) $display("FAIL reset_divzero got %b want 0", DivZero); else pass_cnt++;
    HILORead = 1'b0;
    #3 CLR_n = 1'b1;
    tick();
  endtask

  task automatic test_mult();
    int n;
    issue(2'b00, 32'hFFFFFFFD, 32'd5);
    wait_strobe(n);
    total_cnt++; if (n !== 33) $display("FAIL mult_latency got %0d want 33", n); else pass_cnt++;
    total_cnt++; if (LOWrite !== 1'b1) $display("FAIL mult_lowrite got %b want 1", LOWrite); else pass_cnt++;
    total_cnt++; if (HI_out !== 32'hFFFFFFFF) $display("FAIL mult_hi got %h want ffffffff", HI_out); else pass_cnt++;
    total_cnt++; if (LO_out !== 32'hFFFFFFF1) $display("FAIL mult_lo got %h want fffffff1", LO_out); else pass_cnt++;
    tick();
    total_cnt++; if ({HIWrite, LOWrite} !== 2'b00) $display("FAIL mult_one_cycle got %b want 00", {HIWrite, LOWrite}); else pass_cnt++;
  endtask

  task automatic test_multu();
    int n;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    wait_strobe(n);
    total_cnt++; if (n !== 33) $display("FAIL multu_latency got %0d want 33", n); else pass_cnt++;
    total_cnt++; if (HI_out !== 32'hFFFFFFFE) $display("FAIL multu_hi got %h want fffffffe", HI_out); else pass_cnt++;
    total_cnt++; if (LO_out !== 32'h00000001) $display("FAIL multu_lo got %h want 00000001", LO_out); else pass_cnt++;
    tick();
  endtask

  task automatic test_div();
    int n;
    issue(2'b10, 32'hFFFFFFF9, 32'd2);
    wait_strobe(n);
    total_cnt++; if (LO_out !== 32'hFFFFFFFD) $display("FAIL div_lo got %h want fffffffd", LO_out); else pass_cnt++;
    total_cnt++; if (HI_out !== 32'hFFFFFFFF) $display("FAIL div_hi got %h want ffffffff", HI_out); else pass_cnt++;
    tick();
    issue(2'b11, 32'd100, 32'd7);
    wait_strobe(n);
    total_cnt++; if (LO_out !== 32'd14) $display("FAIL divu_lo got %0d want 14", LO_out); else pass_cnt++;
    total_cnt++; if (HI_out !== 32'd2) $display("FAIL divu_hi got %0d want 2", HI_out); else pass_cnt++;
    tick();
    issue(2'b10, 32'h80000000, 32'hFFFFFFFF);
    wait_strobe(n);
    total_cnt++; if (LO_out !== 32'h80000000) $display("FAIL div_ovf_lo got %h want 80000000", LO_out); else pass_cnt++;
    total_cnt++; if (HI_out !== 32'h00000000) $display("FAIL div_ovf_hi got %h want 0", HI_out); else pass_cnt++;
    total_cnt++; if (DivZero !== 1'b0) $display("FAIL div_ovf_divzero got %b want 0", DivZero); else pass_cnt++;
    tick();
  endtask

  task automatic test_div_zero();
    int n;
    issue(2'b10, 32'h12345678, 32'd0);
    wait_strobe(n);
    total_cnt++; if (n !== ZLAT) $display("FAIL divzero_latency got %0d want %0d", n, ZLAT); else pass_cnt++;
    total_cnt++; if (LO_out !== 32'hFFFFFFFF) $display("FAIL divzero_lo got %h want ffffffff", LO_out); else pass_cnt++;
    total_cnt++; if (HI_out !== 32'h12345678) $display("FAIL divzero_hi got %h want 12345678", HI_out); else pass_cnt++;
    total_cnt++; if (DivZero !== 1'b1) $display("FAIL divzero_flag got %b want 1", DivZero); else pass_cnt++;
    tick();
    issue(2'b00, 32'hDEADBEEF, 32'd0);
    wait_strobe(n);
    total_cnt++; if (n !== ZLAT) $display("FAIL multzero_latency got %0d want %0d", n, ZLAT); else pass_cnt++;
    total_cnt++; if ({HI_out, LO_out} !== 64'd0) $display("FAIL multzero_data got %h want 0", {HI_out, LO_out}); else pass_cnt++;
    total_cnt++; if (DivZero !== 1'b0) $display("FAIL multzero_divzero got %b want 0", DivZero); else pass_cnt++;
    tick();
  endtask

  task automatic test_cancel();
    int n;
    issue(2'b00, 32'd1000, 32'd1000);
    repeat (10) tick();
    HILORead = 1'b1;
    #1;
    total_cnt++; if (Stall !== 1'b1) $display("FAIL cancel_stall got %b want 1", Stall); else pass_cnt++;
    tick();
    HILORead = 1'b0; Cancel = 1'b1;
    tick();
    Cancel = 1'b0;
    total_cnt++; if (Busy !== 1'b0) $display("FAIL cancel_busy got %b want 0", Busy); else pass_cnt++;
    issue(2'b01, 32'd6, 32'd7);
    total_cnt++; if (Busy !== 1'b1) $display("FAIL cancel_restart got %b want 1", Busy); else pass_cnt++;
    wait_strobe(n);
    total_cnt++; if (n !== 33) $display("FAIL cancel_no_strobe got %0d want 33", n); else pass_cnt++;
    total_cnt++; if (LO_out !== 32'd42) $display("FAIL cancel_new_lo got %0d want 42", LO_out); else pass_cnt++;
    tick();
  endtask

  task automatic test_back_to_back();
    int c, n;
    issue(2'b00, 32'd2, 32'd3);
    c = 0;
    repeat (5) begin tick(); c++; end
    Start = 1'b1; Op = 2'b11; A = 32'd100; B = 32'd7;
    #1;
    total_cnt++; if (Stall !== 1'b1) $display("FAIL b2b_stall got %b want 1", Stall); else pass_cnt++;
    while (Stall && c < 40) begin tick(); c++; end
    total_cnt++; if (c !== 32) $display("FAIL b2b_stall_drop got %0d want 32", c); else pass_cnt++;
    tick();
    Start = 1'b0;
    total_cnt++; if (HIWrite !== 1'b1) $display("FAIL b2b_first_strobe got %b want 1", HIWrite); else pass_cnt++;
    total_cnt++; if ({HI_out, LO_out} !== 64'd6) $display("FAIL b2b_first_data got %h want 6", {HI_out, LO_out}); else pass_cnt++;
    total_cnt++; if (Busy !== 1'b1) $display("FAIL b2b_second_busy got %b want 1", Busy); else pass_cnt++;
    wait_strobe(n);
    total_cnt++; if (n !== 33) $display("FAIL b2b_gap got %0d want 33", n); else pass_cnt++;
    total_cnt++; if ({HI_out, LO_out} !== {32'd2, 32'd14}) $display("FAIL b2b_second_data got %h want 2_0000000e", {HI_out, LO_out}); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_run();
    int seen;
    issue(2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF);
    repeat (5) tick();
    CLR_n = 1'b0;
    #1;
    total_cnt++; if (Busy !== 1'b0) $display("FAIL rst_run_busy got %b want 0", Busy); else pass_cnt++;
    total_cnt++; if ({HI_out, LO_out} !== 64'd0) $display("FAIL rst_run_data got %h want 0", {HI_out, LO_out}); else pass_cnt++;
    #2 CLR_n = 1'b1;
    seen = 0;
    repeat (40) begin tick(); if (HIWrite || LOWrite) seen++; end
    total_cnt++; if (seen !== 0) $display("FAIL rst_run_no_strobe got %0d want 0", seen); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_mult();
    test_multu();
    test_div();
    test_div_zero();
    test_cancel();
    test_back_to_back();
    test_reset_mid_run();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
